// File: rtl/fp_add_core_if.sv
//------------------------------------------------------------------------------
// Module : fp_add_core_if
// Brief  : Operand/result handshake bundle for the significand add/normalise core.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fp_add_core_if #(
    parameter int MW = 28,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          SA;
    logic          SB;
    logic          C;
    logic [EW-1:0] E;
    logic [MW-1:0] A;
    logic [MW-1:0] B;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;
    logic          out_zero;
    logic          out_ovf;

    modport master (
        output in_valid, SA, SB, C, E, A, B, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, SA, SB, C, E, A, B, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf
    );
endinterface

`default_nettype wire

// File: rtl/fp_add_core.sv
//------------------------------------------------------------------------------
// Module : fp_add_core
// Brief  : Single-precision significand add/subtract followed by a
//          one-bit-per-cycle normalisation FSM; GRS bits carried through.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_add_core #(
    parameter int MW = 28,
    parameter int EW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_add_core_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [EW-1:0] C_EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] C_EXP_MAX = {EW{1'b1}};

    logic [1:0]    r_state;
    logic          r_sa;
    logic          r_sb;
    logic          r_c;
    logic [MW-1:0] r_a;
    logic [MW-1:0] r_b;
    logic [MW-1:0] r_sum;
    logic [EW-1:0] r_exp;
    logic          r_sign;
    logic          r_valid;
    logic          r_zero;
    logic          r_ovf;
    logic [EW-1:0] w_exp_inc;

    assign w_exp_inc = r_exp + C_EXP_ONE;

    // in_ready is gated by rst_n so it reads 0 for the whole reset window
    assign bus.in_ready  = rst_n && (r_state == S_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_sign  = r_sign;
    assign bus.out_exp   = r_exp;
    assign bus.out_mant  = r_sum;
    assign bus.out_zero  = r_zero;
    assign bus.out_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_c     <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sa    <= bus.SA;
                        r_sb    <= bus.SB;
                        r_c     <= bus.C;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_exp   <= bus.E;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (r_sa == r_sb) begin
                        r_sum  <= r_a + r_b;
                        r_sign <= r_sa;
                    end else if (r_c) begin
                        r_sum  <= r_a - r_b;
                        r_sign <= r_sa;
                    end else begin
                        r_sum  <= r_b - r_a;
                        r_sign <= r_sb;
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_sum == '0) begin
                        r_zero  <= 1'b1;
                        r_sign  <= 1'b0;
                        r_exp   <= '0;
                        r_state <= S_DONE;
                    end else if (r_sum[MW-1]) begin
                        // Carry out: shift right once, folding the lost bit into sticky
                        if (w_exp_inc == C_EXP_MAX) begin
                            r_ovf <= 1'b1;
                            r_sum <= '0;
                        end else begin
                            r_sum <= {1'b0, r_sum[MW-1:2], r_sum[1] | r_sum[0]};
                        end
                        r_exp   <= w_exp_inc;
                        r_state <= S_DONE;
                    end else if (r_sum[MW-2]) begin
                        r_state <= S_DONE;
                    end else if (r_exp == C_EXP_ONE) begin
                        r_exp   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_sum <= {r_sum[MW-2:0], 1'b0};
                        r_exp <= r_exp - C_EXP_ONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises valid; the handshake is only honoured once it is up
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_zero  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
